// File: rtl/dcache_responder_if.sv
// rtl/dcache_responder_if.sv - request/response and memory-port bundle for dcache_responder
interface dcache_responder_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_mem_action;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_addr_next;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  mem_rd_req;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  mem_rd_gnt;
    logic                  mem_rd_valid;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_wr_req;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_ack;
    logic [31:0]           hit_count;
    logic [31:0]           miss_count;

    modport slave (
        input  req_valid, req_mem_action, req_addr, req_addr_next, req_data,
        input  mem_rd_gnt, mem_rd_valid, mem_rd_data, mem_wr_ack,
        output out_valid, out_data, mem_rd_req, mem_rd_addr,
        output mem_wr_req, mem_wr_addr, mem_wr_data, hit_count, miss_count
    );

    modport master (
        output req_valid, req_mem_action, req_addr, req_addr_next, req_data,
        output mem_rd_gnt, mem_rd_valid, mem_rd_data, mem_wr_ack,
        input  out_valid, out_data, mem_rd_req, mem_rd_addr,
        input  mem_wr_req, mem_wr_addr, mem_wr_data, hit_count, miss_count
    );
endinterface

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-through data cache responder; DCACHE_STATS_EN adds hit/miss counters
module dcache_responder #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 5,
    parameter int OFFSET_WIDTH = 2
) (
    input logic               clk,
    input logic               rst_n,
    dcache_responder_if.slave bus
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFFSET_WIDTH;

    typedef enum logic [1:0] {IDLE, RD_REQ, REFILL, WR_REQ} state_t;
    state_t state, state_next;

    logic [LINES-1:0]        line_valid;
    logic [TAG_WIDTH-1:0]    tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]   data_mem [LINES][WORDS];
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [OFFSET_WIDTH-1:0] beat;

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [OFFSET_WIDTH-1:0] req_off;
    logic [TAG_WIDTH-1:0]    fill_tag;
    logic [INDEX_WIDTH-1:0]  fill_idx;
    logic                    hit, is_read, is_write, read_hit, last_beat, unused;

    assign req_tag   = bus.req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_idx   = bus.req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_off   = bus.req_addr[OFFSET_WIDTH-1:0];
    assign fill_tag  = rd_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign fill_idx  = rd_addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign hit       = line_valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign is_read   = bus.req_valid && !bus.req_mem_action;
    assign is_write  = bus.req_valid && bus.req_mem_action;
    assign read_hit  = (state == IDLE) && is_read && hit;
    assign last_beat = (beat == OFFSET_WIDTH'(WORDS - 1));
    assign unused    = ^bus.req_addr_next;

    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;

    always_comb begin
        state_next     = state;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
        case (state)
            IDLE: begin
                if (is_read) begin
                    if (hit) begin
                        bus.out_valid = 1'b1;
                        bus.out_data  = data_mem[req_idx][req_off];
                    end else begin
                        state_next = RD_REQ;
                    end
                end else if (is_write) begin
                    state_next = WR_REQ;
                end
            end
            RD_REQ: begin
                bus.mem_rd_req = 1'b1;
                if (bus.mem_rd_gnt) state_next = REFILL;
            end
            REFILL: begin
                if (bus.mem_rd_valid && last_beat) state_next = IDLE;
            end
            WR_REQ: begin
                bus.mem_wr_req = 1'b1;
                if (bus.mem_wr_ack) begin
                    bus.out_valid = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The line is invalidated on miss so a partially refilled line can never hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            line_valid <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            beat       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (is_read && !hit) begin
                        rd_addr_q           <= {bus.req_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                        line_valid[req_idx] <= 1'b0;
                    end else if (is_write) begin
                        wr_addr_q <= bus.req_addr;
                        wr_data_q <= bus.req_data;
                    end
                end
                RD_REQ: if (bus.mem_rd_gnt) beat <= '0;
                REFILL: begin
                    if (bus.mem_rd_valid) begin
                        beat <= beat + 1'b1;
                        if (last_beat) line_valid[fill_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && is_write && hit)
            data_mem[req_idx][req_off] <= bus.req_data;
        if (state == REFILL && bus.mem_rd_valid) begin
            data_mem[fill_idx][beat] <= bus.mem_rd_data;
            if (last_beat) tag_mem[fill_idx] <= fill_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        req_open;
    logic [31:0] hit_q, miss_q;

    // req_open marks a request already seen in an earlier cycle, so a held request counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_open <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            req_open <= bus.req_valid && !bus.out_valid;
            if (read_hit && !req_open) hit_q <= hit_q + 32'd1;
            if (state == IDLE && state_next == RD_REQ) miss_q <= miss_q + 32'd1;
        end
    end

    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
`else
    logic unused_hit;
    assign unused_hit     = read_hit;
    assign bus.hit_count  = 32'd0;
    assign bus.miss_count = 32'd0;
`endif
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder end of the data-cache request interface. Accepts load/store requests from the EX/MEM side (valid, mem_action, addr, addr_next, data) and returns the cache output (valid, data).
- Direct-mapped, write-through, no-write-allocate cache with a blocking miss FSM that refills whole lines from a simple memory port.
- A hit answers combinationally in the request cycle, so the requester can tell a hit from a miss in the same cycle.

Parameters:
- ADDR_WIDTH, 26, word-address width.
- DATA_WIDTH, 32, data word width.
- INDEX_WIDTH, 5, log2 of line count (32 lines).
- OFFSET_WIDTH, 2, log2 of words per line (4 words).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present; held stable by requester until out_valid
- req_mem_action  in  1  0=READ, 1=WRITE
- req_addr  in  ADDR_WIDTH  word address
- req_addr_next  in  ADDR_WIDTH  next-address hint; unused, reserved
- req_data  in  DATA_WIDTH  store data
- out_valid  out  1  response valid (read data ready / write complete)
- out_data  out  DATA_WIDTH  read data; 0 when out_valid=0
- mem_rd_req  out  1  refill request, held until mem_rd_gnt
- mem_rd_addr  out  ADDR_WIDTH  line-aligned refill address (offset bits 0)
- mem_rd_gnt  in  1  memory accepted refill request
- mem_rd_valid  in  1  one refill beat, beats in offset order 0..N-1
- mem_rd_data  in  DATA_WIDTH  refill beat data
- mem_wr_req  out  1  write-through request, held until mem_wr_ack
- mem_wr_addr  out  ADDR_WIDTH  store address
- mem_wr_data  out  DATA_WIDTH  store data
- mem_wr_ack  in  1  store committed
- hit_count  out  32  read-hit counter (optional feature)
- miss_count  out  32  read-miss counter (optional feature)

Behaviour:
- Address split: tag = upper ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH bits, then index, then offset.
- Storage: valid bits and tags in flops; data array read combinationally.
- Reset (async, rst_n=0): all valid bits 0; FSM=IDLE; out_valid=0, out_data=0, mem_rd_req=0, mem_wr_req=0, mem_rd_addr=0, mem_wr_addr=0, mem_wr_data=0; counters 0.
- FSM states: IDLE, RD_REQ, REFILL, WR_REQ.
- IDLE, read hit (req_valid, READ, valid[index], tag match): out_valid=1 and out_data=word in the same cycle. Zero latency; stay in IDLE.
- IDLE, read miss: out_valid=0; latch line address; next state RD_REQ.
- RD_REQ: mem_rd_req=1 with the latched line address. On mem_rd_gnt go to REFILL, beat counter=0.
- REFILL: each mem_rd_valid writes the beat to data[index][counter] and increments the counter. On the last beat (counter=2^OFFSET_WIDTH-1), write the tag, set valid and go to IDLE.
- After refill, the held request hits on the next cycle: miss latency = grant wait + beats + 1 cycle.
- Before refill completes, valid[index] for the line is cleared at RD_REQ entry, so a partial line is never visible.
- IDLE, write: next state WR_REQ. If the line is a hit, the word is updated in the same cycle. A write miss does not allocate.
- WR_REQ: mem_wr_req=1 with the latched address and data. On mem_wr_ack, out_valid=1 for that cycle; return to IDLE.
- Only one outstanding request; no new request is accepted outside IDLE.
- req_valid dropped mid-refill (requester flush): refill still completes and installs the line. out_valid is not asserted for the abandoned request.
- req_valid dropped in WR_REQ: the store still commits (stores are not cancellable).
- Simultaneous mem_rd_gnt and mem_rd_valid in one cycle: the beat is ignored. Memory must start beats at least 1 cycle after gnt.
- Counters wrap at 2^32.

Optional Feature:
- DCACHE_STATS_EN defined:
  - hit_count increments once per read that hits in IDLE while FSM is IDLE, counted only in the first cycle of the request.
  - miss_count increments once per RD_REQ entry.
- Undefined: both ports are tied to constant 0 and no counter flops are built.

Test Plan:
- Reset then read addr 0x000040 → miss. mem_rd_req=1 with mem_rd_addr=0x000040. After gnt and 4 beats (0xA0..0xA3), one cycle later out_valid=1, out_data=0xA0.
- Read 0x000042 right after that refill → out_valid=1 in the same cycle, out_data=0xA2, no mem_rd_req.
- Write 0x000041 with data 0xDEADBEEF (hit) → mem_wr_req=1 with mem_wr_addr=0x000041. On ack, out_valid=1. A following read of 0x000041 returns 0xDEADBEEF with no refill.
- Write 0x001000 (miss), then read 0x001000 → the store goes to memory only, and the read misses (no allocate).
- Conflict: read 0x000040, then 0x000840 (same index, different tag) → the second read misses and refills. Re-reading 0x000040 misses again.
- Assert rst_n=0 during beat 2 of a refill → all outputs 0 immediately. A later read of the same address misses (valid cleared). With DCACHE_STATS_EN, hit_count=0 and miss_count=0 after reset.
